// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, bias and the packed fp32 layout used by the
// integer-to-float converter.
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/itof_pipe_lzc.sv
// Leading-zero counter of width W; returns W when the input is all zeros.
module lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_bits,
  output logic [CW-1:0] cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_bits[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter (abs, normalise, round).
// Optional build macro ITOF_INEXACT_EN adds the out_inexact flag output.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W           = 32,
  parameter int SIGNED_DEFAULT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
`ifdef ITOF_INEXACT_EN
  ,
  output logic            out_inexact
`endif
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int TW = IN_W + 24;

  if (IN_W < 8 || IN_W > 64 || SIGNED_DEFAULT < 0 || SIGNED_DEFAULT > 1) begin : g_bad_param
    $error("itof_pipe: IN_W must be 8..64 and SIGNED_DEFAULT 0 or 1");
  end

  logic advance;

  logic            s1_valid_d, s1_valid_q;
  logic            s1_sign_d, s1_sign_q;
  logic [IN_W-1:0] s1_mag_d, s1_mag_q;

  logic            s2_valid_d, s2_valid_q;
  logic            s2_sign_d, s2_sign_q;
  logic            s2_zero_d, s2_zero_q;
  logic [7:0]      s2_exp_d, s2_exp_q;
  logic [IN_W-2:0] s2_frac_d, s2_frac_q;

  logic            out_valid_d, out_valid_q;
  logic [31:0]     out_data_d, out_data_q;

  logic [CW-1:0]   lz;
  logic [IN_W-1:0] norm_full;
  logic [TW-1:0]   tail;
  logic [22:0]     man;
  logic            guard_b, round_b, sticky_b, round_up;
  logic [23:0]     man_r;
  fp32_t           res;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_valid_d = in_valid;
    s1_sign_d  = in_signed & in_data[IN_W-1];
    s1_mag_d   = s1_sign_d ? (~in_data + IN_W'(1)) : in_data;
  end

  lzc #(.W(IN_W)) u_lzc (
    .in_bits (s1_mag_q),
    .cnt     (lz)
  );

  always_comb begin
    norm_full  = s1_mag_q << lz;
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_zero_d  = ~norm_full[IN_W-1];
    s2_frac_d  = norm_full[IN_W-2:0];
    s2_exp_d   = 8'(FP32_BIAS + IN_W - 1) - 8'(lz);
  end

  // Bits below the hidden one, padded so narrow inputs still yield G/R/S.
  always_comb begin
    tail     = {s2_frac_q, 25'b0};
    man      = tail[TW-1 -: 23];
    guard_b  = tail[TW-24];
    round_b  = tail[TW-25];
    sticky_b = |tail[TW-26:0];
    round_up = guard_b & (round_b | sticky_b | man[0]);
    man_r    = {1'b0, man} + 24'(round_up);
    res.sign = s2_sign_q;
    res.exp  = s2_exp_q + 8'(man_r[23]);
    res.man  = man_r[22:0];
    if (s2_zero_q) res = '0;
    out_valid_d = s2_valid_q;
    out_data_d  = res;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_sign_q <= s2_sign_d;
      s2_zero_q <= s2_zero_d;
      s2_exp_q  <= s2_exp_d;
      s2_frac_q <= s2_frac_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef ITOF_INEXACT_EN
  logic out_inexact_d, out_inexact_q;

  always_comb out_inexact_d = guard_b | round_b | sticky_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        out_inexact_q <= 1'b0;
    else if (advance) out_inexact_q <= out_inexact_d;
  end

  assign out_inexact = out_inexact_q;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: directed table, backpressure, reset and a
// randomised width sweep against an independent integer rounding model.
module tb_itof_pipe;

  typedef struct {
    logic [31:0] data;
    logic        inx;
  } exp_t;

  typedef struct {
    logic [31:0] din;
    logic        sgn;
    logic [31:0] f;
    logic        inx;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [31:0] exp_data_in;
  logic        exp_inx_in;

  logic        w_valid, w_signed, w_ready_tie;
  logic        r8, r16, r64, v8, v16, v64;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [63:0] d64;
  logic [31:0] o8, o16, o64;
  exp_t        x8, x16, x64;

`ifdef ITOF_INEXACT_EN
  logic out_inexact, n8, n16, n64;
`endif

  exp_t q32[$], q8[$], q16[$], q64[$];
  exp_t e32, e8, e16, e64;
  int   n_pass = 0, n_total = 0;

  itof_pipe #(.IN_W(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(out_inexact)
`endif
  );

  itof_pipe #(.IN_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(w_valid), .in_ready(r8),
    .in_data(d8), .in_signed(w_signed), .out_valid(v8),
    .out_ready(w_ready_tie), .out_data(o8)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(n8)
`endif
  );

  itof_pipe #(.IN_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(w_valid), .in_ready(r16),
    .in_data(d16), .in_signed(w_signed), .out_valid(v16),
    .out_ready(w_ready_tie), .out_data(o16)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(n16)
`endif
  );

  itof_pipe #(.IN_W(64)) dut64 (
    .clk(clk), .rstn(rstn), .in_valid(w_valid), .in_ready(r64),
    .in_data(d64), .in_signed(w_signed), .out_valid(v64),
    .out_ready(w_ready_tie), .out_data(o64)
`ifdef ITOF_INEXACT_EN
    , .out_inexact(n64)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: shift the leading one to bit 63, keep 23 bits, round with a
  // guard bit plus a merged sticky of everything below it.
  function automatic exp_t ref_f32(input logic [63:0] val, input int w, input logic sgn);
    logic [63:0] mask, v, mag, m;
    logic        neg, g, st;
    logic [23:0] mn;
    int          p, e;
    exp_t        r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = val & mask;
    neg  = sgn && v[w-1];
    mag  = neg ? ((~v + 64'd1) & mask) : v;
    r.data = '0;
    r.inx  = 1'b0;
    if (mag == 64'd0) return r;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    m  = mag << (63 - p);
    mn = {1'b0, m[62:40]};
    g  = m[39];
    st = |m[38:0];
    if (g && (st || mn[0])) mn = mn + 24'd1;
    e = 127 + p + int'(mn[23]);
    r.data = {neg, 8'(e), mn[22:0]};
    r.inx  = g | st;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) begin
        if (q32.size() == 0) chk("unexpected_out", out_valid, 1'b0);
        else if (out_ready) begin
          e32 = q32.pop_front();
          chk("out_data", out_data, e32.data);
`ifdef ITOF_INEXACT_EN
          chk("out_inexact", out_inexact, e32.inx);
`endif
        end else begin
          chk("stall_hold", out_data, q32[0].data);
        end
      end
      if (in_valid && in_ready) q32.push_back('{exp_data_in, exp_inx_in});
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (v8) begin
        if (q8.size() == 0) chk("w8_unexpected", v8, 1'b0);
        else begin
          e8 = q8.pop_front();
          chk("w8_data", o8, e8.data);
`ifdef ITOF_INEXACT_EN
          chk("w8_inexact", n8, e8.inx);
`endif
        end
      end
      if (v16) begin
        if (q16.size() == 0) chk("w16_unexpected", v16, 1'b0);
        else begin
          e16 = q16.pop_front();
          chk("w16_data", o16, e16.data);
`ifdef ITOF_INEXACT_EN
          chk("w16_inexact", n16, e16.inx);
`endif
        end
      end
      if (v64) begin
        if (q64.size() == 0) chk("w64_unexpected", v64, 1'b0);
        else begin
          e64 = q64.pop_front();
          chk("w64_data", o64, e64.data);
`ifdef ITOF_INEXACT_EN
          chk("w64_inexact", n64, e64.inx);
`endif
        end
      end
      if (w_valid && r8)  q8.push_back(x8);
      if (w_valid && r16) q16.push_back(x16);
      if (w_valid && r64) q64.push_back(x64);
    end
  end

  task automatic send(input logic [31:0] d, input logic s, input logic [31:0] ed, input logic ei);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_signed = s;
    exp_data_in = ed; exp_inx_in = ei;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [31:0] d, input logic s);
    exp_t r;
    r = ref_f32({32'b0, d}, 32, s);
    send(d, s, r.data, r.inx);
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(q32.size()), 64'd0);
  endtask

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   idx, sent, cyc;
    logic acc, s;
    logic [31:0] d;
    exp_t r;
    logic [31:0] bp_d[4];
    logic        bp_s[4];

    tbl[0]  = '{32'h00000000, 1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{32'h00000001, 1'b1, 32'h3F800000, 1'b0};
    tbl[2]  = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0};
    tbl[3]  = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0};
    tbl[4]  = '{32'h80000000, 1'b0, 32'h4F000000, 1'b0};
    tbl[5]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1};
    tbl[6]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1};
    tbl[7]  = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1};
    tbl[8]  = '{32'hFFFFFFFE, 1'b1, 32'hC0000000, 1'b0};
    tbl[9]  = '{32'h00FFFFFF, 1'b0, 32'h4B7FFFFF, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 1'b1, 32'h4F000000, 1'b1};
    tbl[11] = '{32'hFFFFFFFB, 1'b1, 32'hC0A00000, 1'b0};
    tbl[12] = '{32'h01000002, 1'b0, 32'h4B800001, 1'b0};

    in_valid = 0; in_data = 0; in_signed = 0; out_ready = 1;
    exp_data_in = 0; exp_inx_in = 0;
    w_valid = 0; w_signed = 0; w_ready_tie = 1; d8 = 0; d16 = 0; d64 = 0;
    x8 = '{32'h0, 1'b0}; x16 = x8; x64 = x8;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_in_ready", in_ready, 1'b1);
`ifdef ITOF_INEXACT_EN
    chk("reset_out_inexact", out_inexact, 1'b0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;

    foreach (tbl[i]) send(tbl[i].din, tbl[i].sgn, tbl[i].f, tbl[i].inx);
    drain();

    // Backpressure: out_ready low for five cycles while offering four words.
    bp_d = '{32'h00000005, 32'hFFFFFFF0, 32'h00ABCDEF, 32'h12345678};
    bp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        r = ref_f32({32'b0, bp_d[idx]}, 32, bp_s[idx]);
        in_data = bp_d[idx]; in_signed = bp_s[idx];
        exp_data_in = r.data; exp_inx_in = r.inx;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (idx < 4) begin
      send_rand(bp_d[idx], bp_s[idx]);
      idx++;
    end
    drain();

    // Random traffic with random backpressure.
    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        d = $urandom >> $urandom_range(0, 31);
        s = 1'($urandom_range(0, 1));
        r = ref_f32({32'b0, d}, 32, s);
        in_data = d; in_signed = s; exp_data_in = r.data; exp_inx_in = r.inx;
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    chk("rand32_sent", 64'(sent), 64'd300);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with three results in flight.
    send_rand(32'h00000011, 1'b0);
    send_rand(32'hFFFFFF00, 1'b1);
    send_rand(32'h0000BEEF, 1'b0);
    chk("rst_pre_out_valid", out_valid, 1'b1);
    rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    q32.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    r = ref_f32({32'b0, 32'h00000007}, 32, 1'b0);
    in_valid = 1'b1; in_data = 32'h00000007; in_signed = 1'b0;
    exp_data_in = r.data; exp_inx_in = r.inx;
    @(negedge clk);
    chk("rst_in_ready_after", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("rst_latency", out_valid, (k == 3));
    end
    drain();

    // Width sweep: 500 unsigned then 500 signed operands per width.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      w_valid  = 1'b1;
      w_signed = (i >= 500);
      d8  = 8'($urandom);
      d16 = 16'($urandom >> $urandom_range(0, 15));
      d64 = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i == 0 || i == 500) begin
        d8 = 8'h80; d16 = 16'h8000; d64 = 64'h8000_0000_0000_0000;
      end
      x8  = ref_f32({56'b0, d8}, 8, w_signed);
      x16 = ref_f32({48'b0, d16}, 16, w_signed);
      x64 = ref_f32(d64, 64, w_signed);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("w8_drain", 64'(q8.size()), 64'd0);
    chk("w16_drain", 64'(q16.size()), 64'd0);
    chk("w64_drain", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
